// File: rtl/img_frame_store.sv
// Dual-bank 64x64 RGB888 frame store: stream load, engine random access, raster dump.
// Optional IMG_WCOUNT_EN adds a saturating count of committed engine writes (wr_count).
module img_frame_store (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_pix,
  output logic        proc_run,
  input  logic [5:0]  row,
  input  logic [5:0]  col,
  output logic [23:0] in_pix,
  input  logic        out_we,
  input  logic [23:0] out_pix,
  input  logic        proc_done,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [23:0] m_pix,
  output logic        m_last,
`ifdef IMG_WCOUNT_EN
  output logic [12:0] wr_count,
`endif
  output logic [1:0]  phase
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_PROC = 2'd1,
    ST_DUMP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] lcnt_q, lcnt_d;
  logic [11:0] dcnt_q, dcnt_d;

  logic [23:0] in_bank  [4096];
  logic [23:0] out_bank [4096];

  logic        load_acc;
  logic        eng_wr;
  logic        dump_hs;
  logic [11:0] eng_addr;

  assign eng_addr = {row, col};
  assign load_acc = (state_q == ST_LOAD) && s_valid;
  assign eng_wr   = (state_q == ST_PROC) && out_we;
  assign dump_hs  = (state_q == ST_DUMP) && m_ready;

  // State register and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      lcnt_q  <= 12'd0;
      dcnt_q  <= 12'd0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_LOAD: begin
        dcnt_d = 12'd0;
        if (load_acc) begin
          lcnt_d = lcnt_q + 12'd1;
          if (lcnt_q == 12'hFFF) state_d = ST_PROC;
        end
      end
      ST_PROC: begin
        lcnt_d = 12'd0;
        dcnt_d = 12'd0;
        if (proc_done) state_d = ST_DUMP;
      end
      ST_DUMP: begin
        lcnt_d = 12'd0;
        if (dump_hs) begin
          dcnt_d = dcnt_q + 12'd1;
          if (dcnt_q == 12'hFFF) state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
        lcnt_d  = 12'd0;
        dcnt_d  = 12'd0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    s_ready  = 1'b0;
    proc_run = 1'b0;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    case (state_q)
      ST_LOAD: s_ready  = 1'b1;
      ST_PROC: proc_run = 1'b1;
      ST_DUMP: begin
        m_valid = 1'b1;
        m_last  = (dcnt_q == 12'hFFF);
      end
      default: ;
    endcase
  end

  assign phase = state_q;

  // Banks are deliberately outside the reset domain so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (load_acc) in_bank[lcnt_q] <= s_pix;
  end

  always_ff @(posedge clk) begin
    if (eng_wr) out_bank[eng_addr] <= out_pix;
  end

  assign in_pix = in_bank[eng_addr];
  assign m_pix  = out_bank[dcnt_q];

`ifdef IMG_WCOUNT_EN
  logic [12:0] wr_count_q, wr_count_d;

  always_comb begin
    wr_count_d = wr_count_q;
    if (load_acc && (lcnt_q == 12'hFFF)) begin
      wr_count_d = 13'd0;
    end else if (eng_wr && (wr_count_q != 13'h1FFF)) begin
      wr_count_d = wr_count_q + 13'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_count_q <= 13'd0;
    else        wr_count_q <= wr_count_d;
  end

  assign wr_count = wr_count_q;
`endif

endmodule

// File: doc/img_frame_store.md
# img_frame_store

Dual-bank 64x64 RGB888 frame store: the memory-side responder for the image processing engine's row/col read and out_we write port. It loads a source image from an input pixel stream, serves the engine's random-access reads from the input bank, captures the engine's writes into the output bank, and streams the output bank out in raster order. It sits between the testbench/host pixel streams and the processing FSM.

## Interface
- No parameters. Geometry is fixed at 64 rows x 64 columns x 24 bits (R 23:16, G 15:8, B 7:0).
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  load stream pixel valid
- s_ready  out  1  load stream ready; high only in LOAD
- s_pix  in  24  load stream pixel, raster order (row 0 col 0 first)
- proc_run  out  1  high while in PROC; the processing engine operates only while this is high
- row  in  6  engine-selected row
- col  in  6  engine-selected column
- in_pix  out  24  input-bank pixel at {row,col}
- out_we  in  1  engine write enable for the output bank
- out_pix  in  24  engine write data, written at {row,col}
- proc_done  in  1  engine completion flag (final done of the operation chain)
- m_valid  out  1  dump stream valid; high only in DUMP
- m_ready  in  1  dump stream ready
- m_pix  out  24  output-bank pixel at dump address
- m_last  out  1  high with the pixel at address 4095
- phase  out  2  current state: 0 LOAD, 1 PROC, 2 DUMP

## Operation
- Address mapping: addr = {row, col} (12 bits, row-major). Load and dump counters use the same mapping.
- States: LOAD -> PROC -> DUMP -> LOAD.
- LOAD: s_ready=1. Each s_valid&&s_ready cycle writes s_pix to in_bank[lcnt] and increments lcnt. Accepting at lcnt=4095 -> PROC, lcnt wraps to 0.
- PROC: proc_run=1. in_pix = in_bank[{row,col}] combinationally (asynchronous read). out_we=1 on a clock edge writes out_pix to out_bank[{row,col}]. Writes to the same address overwrite; the last one wins. proc_done=1 sampled on a clock edge -> DUMP, dcnt=0. A write in the same cycle as proc_done is still committed.
- DUMP: m_valid=1, m_pix = out_bank[dcnt] combinationally, m_last = (dcnt==4095). dcnt advances on m_valid&&m_ready; m_pix/m_last hold while m_ready=0. Handshake with m_last -> LOAD, dcnt=0.
- in_pix is driven from in_bank at {row,col} in every state; it is meaningful only in PROC.
- Out-of-state inputs are ignored: out_we outside PROC, s_valid outside LOAD, proc_done outside PROC.
- The banks are not cleared. Output-bank locations never written in PROC dump their previous contents (X after power-up).

## Timing
- Reset (asynchronous, rst_n=0): phase=0 (LOAD), lcnt=0, dcnt=0, s_ready=1, proc_run=0, m_valid=0, m_last=0. m_pix and in_pix follow bank contents. Bank contents are retained.
- Reset mid-LOAD, mid-PROC or mid-DUMP returns to LOAD with counters 0. The next load overwrites the input bank from address 0.
- Load throughput: 1 pixel/cycle. A full load takes at least 4096 cycles. PROC is entered on the edge of the 4096th accept.
- Read latency: 0 cycles. in_pix reflects row/col in the same cycle.
- Write latency: 1 edge. Data is visible on m_pix or via the dump on the next cycle.
- proc_run falls on the edge where proc_done is sampled. m_valid rises on that same edge.
- Dump throughput: 1 pixel/cycle with m_ready held high, giving 4096 cycles. The LOAD state is re-entered on the edge of the last handshake.

## Configuration
- IMG_WCOUNT_EN defined: adds output wr_count (13 bits). It counts out_we writes committed in PROC, saturates at 8191, resets to 0 on rst_n and on entry to PROC, and holds through DUMP and the following LOAD.
- IMG_WCOUNT_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Load ramp s_pix = addr (0x000000..0x000FFF), s_valid held high -> s_ready low and proc_run high after exactly 4096 accepts. With row=5, col=7: in_pix=0x000147 in the same cycle.
- Load with s_valid toggling every other cycle -> 4096 accepts over 8192 cycles. PROC is entered only after the 4096th accept, and no pixel is dropped or duplicated (verify via readback).
- In PROC, write out_pix=0xFF00AA at {63,63} and 0x123456 at {0,0}. Write 0xABCDEF then 0x111111 to {10,20}. Assert proc_done -> dump shows 0x123456 at index 0, 0x111111 at index 660, and 0xFF00AA at index 4095 with m_last=1.
- In DUMP with m_ready low for 3 cycles at dcnt=100 -> m_pix and m_last stable, and dcnt still 100 afterwards. After the final handshake -> phase=0 and s_ready=1.
- Assert rst_n=0 at load pixel 2000, then release and reload a full frame -> readback in PROC matches the second frame. out_we pulsed during LOAD -> the output bank is unchanged.
- With IMG_WCOUNT_EN defined, 4096 distinct writes plus 10 rewrites -> wr_count=4106 in DUMP. On re-entry to PROC -> wr_count=0.
